button_events: RTL
==================

Name: button_events

Overview:
- Input-side counterpart to the display path: conditions raw front-panel buttons (reset, set_time, position_bt, change_bt) into clean, single-cycle events for the clock core.
- Replaces the core's free-running counter-bit sampling of button levels.
- Per-button functions: synchroniser, debouncer, edge detector and auto-repeat generator.
- Sits between the board pins and the clock/time-setting logic.

Parameters:
- N_BTN, 4, number of independent buttons.
- DEBOUNCE_CYC, 240000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz).
- REPEAT_DELAY, 6000000, cycles from press event to first repeat pulse (0.5 s).
- REPEAT_PERIOD, 2097152, cycles between subsequent repeat pulses.
- LONG_CYC, 24000000, hold time in cycles before btn_long asserts (2 s).

Ports:
- CLK, input, 1, system clock (12 MHz).
- reset, input, 1, asynchronous, active-low; 0 = reset.
- btn_raw, input, N_BTN, raw button levels, active-high, asynchronous to CLK.
- btn_level, output, N_BTN, debounced level.
- btn_press, output, N_BTN, one-cycle pulse on accepted press.
- btn_release, output, N_BTN, one-cycle pulse on accepted release.
- btn_repeat, output, N_BTN, one-cycle auto-repeat pulse while held.
- btn_long, output, N_BTN, level; high while held ≥ LONG_CYC cycles.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-safe release):
  - All outputs 0.
  - Synchroniser flops 0; all counters 0; every FSM in IDLE.
- Per button i, fully independent; any combination of buttons may be active in the same cycle.
- Synchroniser: 2 flops; sync[i] lags btn_raw[i] by 2 cycles.
- Debounce:
  - The counter increments while sync[i] differs from btn_level[i] and clears whenever they are equal.
  - When the count reaches DEBOUNCE_CYC-1, btn_level[i] toggles on the next edge and the counter clears.
  - Any bounce restarts the count.
  - Latency from a clean raw edge to the btn_level change is 2+DEBOUNCE_CYC cycles.
- Edges:
  - btn_press[i] is high for exactly the one cycle in which btn_level[i] is first 1.
  - btn_release[i] is high for the first cycle in which btn_level[i] is 0 after being 1.
- Hold FSM per button:
  - IDLE -> HELD on the press event. The hold counter clears and btn_long is low.
  - HELD -> REPEAT when the hold counter reaches REPEAT_DELAY-1. Pulse btn_repeat and clear the repeat counter.
  - REPEAT: pulse btn_repeat each time the repeat counter reaches REPEAT_PERIOD-1, then clear the counter.
  - HELD or REPEAT -> IDLE on the release event. btn_repeat and btn_long drop the same cycle btn_level falls; no repeat pulse on that cycle.
- Repeat pulse timing: first btn_repeat is REPEAT_DELAY cycles after btn_press; subsequent pulses every REPEAT_PERIOD cycles.
- btn_press and btn_repeat are never high in the same cycle.
- Long press:
  - A separate saturating hold counter runs in HELD and REPEAT.
  - btn_long is set when the counter reaches LONG_CYC-1 and stays high until release.
  - The counter saturates and does not wrap.
- Counter widths: $clog2 of the largest governing parameter + 1. No wrap is allowed within a hold of any length.
- Reset mid-hold: all state is cleared. A button still held when reset releases is re-debounced and produces a fresh btn_press after 2+DEBOUNCE_CYC cycles.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYC cycles produces no event.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: REPEAT state and btn_repeat behave as specified.
- Undefined:
  - REPEAT state and repeat counter are not built.
  - btn_repeat is tied to 0.
  - FSM stays in HELD until release.
  - btn_long and all other outputs are unchanged.

Test Plan:
(All scenarios use DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, LONG_CYC=20, N_BTN=4.)
- Clean press/release: btn_raw[0] rises at cycle 0, held 30 cycles.
  - btn_press[0] pulses at cycle 6.
  - btn_release[0] pulses 6 cycles after the fall.
  - No other bit toggles.
- Bounce: btn_raw[1] toggles 1,0,1,0 on alternate cycles, then stays 1.
  - Exactly one btn_press[1], 6 cycles after the final rise.
  - A 3-cycle glitch alone gives no event.
- Auto-repeat/long: btn_raw[2] held 40 cycles after press.
  - btn_repeat[2] at press+10, +13, +16, ...
  - btn_long[2] high from press+20 until release.
  - Undefining BTN_REPEAT_EN leaves btn_repeat=0 with btn_long unchanged.
- Simultaneous: btn_raw[3:0]=4'b1111 in one cycle.
  - All four btn_press bits pulse in the same cycle, 6 cycles later.
- Reset mid-hold: reset=0 for 2 cycles during REPEAT on button 0, raw still held.
  - All outputs 0 immediately.
  - New btn_press[0] 6 cycles after reset deasserts.
- Release during repeat: release at press+14.
  - No btn_repeat after btn_level falls.
  - btn_long never asserts.

Source files
------------

// File: rtl/button_events.sv
// button_events: conditions raw front-panel buttons into clean single-cycle
// events for the clock core. Each button gets its own 2-flop synchroniser,
// debouncer, press/release edge detector, long-press timer and (optionally)
// an auto-repeat generator.
// Optional feature macro: BTN_REPEAT_EN. When defined, a held button produces
// periodic btn_repeat pulses. When undefined, the REPEAT state and its counters
// are not built and btn_repeat is tied low. btn_long is unaffected either way.
module button_events #(
    parameter int N_BTN         = 4,
    parameter int DEBOUNCE_CYC  = 240000,
    parameter int REPEAT_DELAY  = 6000000,
    parameter int REPEAT_PERIOD = 2097152,
    parameter int LONG_CYC      = 24000000
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_long
);

    // One spare bit on every counter so the terminal value always fits.
    localparam int DB_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam int LONG_W = $clog2(LONG_CYC) + 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

`ifdef BTN_REPEAT_EN
    localparam int DLY_W = $clog2(REPEAT_DELAY) + 1;
    localparam int RPT_W = $clog2(REPEAT_PERIOD) + 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_REPEAT
    } hold_state_t;
`else
    typedef enum logic {
        ST_IDLE,
        ST_HELD
    } hold_state_t;

    assign btn_repeat = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic              sync1_reg;
            logic              sync2_reg;
            logic              level_reg;
            logic              press_reg;
            logic              release_reg;
            logic              long_reg;
            logic [DB_W-1:0]   db_cnt_reg;
            logic [LONG_W-1:0] long_cnt_reg;
            hold_state_t       state_reg;
            logic              accept;
            logic              rise_evt;
            logic              fall_evt;
`ifdef BTN_REPEAT_EN
            logic [DLY_W-1:0]  dly_cnt_reg;
            logic [RPT_W-1:0]  rpt_cnt_reg;
            logic              repeat_reg;
`endif

            // A level change is accepted on the cycle the mismatch count hits its limit.
            assign accept   = (sync2_reg != level_reg) && (db_cnt_reg == DB_LAST);
            assign rise_evt = accept && !level_reg;
            assign fall_evt = accept && level_reg;

            // Two-flop synchroniser for the asynchronous pin.
            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debounce: count consecutive mismatching samples, flip the level and emit edge pulses.
            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    db_cnt_reg  <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= rise_evt;
                    release_reg <= fall_evt;
                    if ((sync2_reg == level_reg) || accept) begin
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                    if (accept) begin
                        level_reg <= ~level_reg;
                    end
                end
            end

            // Hold FSM: long-press timer always, auto-repeat pulses when built in; release wins.
            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    state_reg    <= ST_IDLE;
                    long_cnt_reg <= '0;
                    long_reg     <= 1'b0;
`ifdef BTN_REPEAT_EN
                    dly_cnt_reg  <= '0;
                    rpt_cnt_reg  <= '0;
                    repeat_reg   <= 1'b0;
`endif
                end else begin
`ifdef BTN_REPEAT_EN
                    repeat_reg <= 1'b0;
`endif
                    if (fall_evt) begin
                        state_reg    <= ST_IDLE;
                        long_cnt_reg <= '0;
                        long_reg     <= 1'b0;
                    end else begin
                        case (state_reg)
                            ST_IDLE: begin
                                if (rise_evt) begin
                                    state_reg    <= ST_HELD;
                                    long_cnt_reg <= '0;
                                    long_reg     <= 1'b0;
`ifdef BTN_REPEAT_EN
                                    dly_cnt_reg  <= '0;
`endif
                                end
                            end
                            ST_HELD: begin
`ifdef BTN_REPEAT_EN
                                if (dly_cnt_reg == DLY_LAST) begin
                                    state_reg   <= ST_REPEAT;
                                    repeat_reg  <= 1'b1;
                                    rpt_cnt_reg <= '0;
                                end else begin
                                    dly_cnt_reg <= dly_cnt_reg + DLY_W'(1);
                                end
`endif
                            end
`ifdef BTN_REPEAT_EN
                            ST_REPEAT: begin
                                if (rpt_cnt_reg == RPT_LAST) begin
                                    repeat_reg  <= 1'b1;
                                    rpt_cnt_reg <= '0;
                                end else begin
                                    rpt_cnt_reg <= rpt_cnt_reg + RPT_W'(1);
                                end
                            end
`endif
                            default: state_reg <= ST_IDLE;
                        endcase

                        // Long-press counter saturates at its terminal value for arbitrarily long holds.
                        if (state_reg != ST_IDLE) begin
                            if (long_cnt_reg == LONG_LAST) begin
                                long_reg <= 1'b1;
                            end else begin
                                long_cnt_reg <= long_cnt_reg + LONG_W'(1);
                            end
                        end
                    end
                end
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
            assign btn_long[gi]    = long_reg;
`ifdef BTN_REPEAT_EN
            assign btn_repeat[gi]  = repeat_reg;
`endif
        end
    endgenerate

endmodule
